// File: rtl/ram_responder.sv
// ram_responder: CPU-bus byte RAM with a loader port, step-clocked CPU writes
// and a zero-fill clear engine that runs after reset and on request.
module ram_responder #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk_qzt,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clk_in,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          clr_req,
  output logic          busy,
  output logic          wr_collision
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic clk_in_old, tick, ld_wr, cpu_wr, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk_qzt or negedge reset_n)
    if (!reset_n) state <= CLEAR;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == CLEAR) ? ((clr_cnt == AW'(DEPTH - 1)) ? READY : CLEAR)
                                 : (clr_req ? CLEAR : READY);
  always_comb begin
    busy         = state == CLEAR;
    ld_ready     = state == READY;
    tick         = clk_in && !clk_in_old;
    ld_wr        = ld_ready && ld_valid;
    cpu_wr       = ld_ready && en && tick && cpu_we;
    wr_collision = ld_wr && cpu_wr;
    mem_we       = busy || ld_wr || cpu_wr;
    mem_addr     = busy ? clr_cnt : (ld_wr ? ld_addr : cpu_addr);
    mem_wdata    = busy ? '0 : (ld_wr ? ld_data : cpu_wdata);
  end
  // clk_in_old resets high so a strobe already high at release is not a tick
  always_ff @(posedge clk_qzt or negedge reset_n)
    if (!reset_n) begin
      clr_cnt    <= '0;
      clk_in_old <= 1'b1;
    end else begin
      clk_in_old <= clk_in;
      clr_cnt    <= busy ? clr_cnt + 1'b1 : '0;
    end
  // single write port: clear, then loader, then CPU; read-before-write
  always_ff @(posedge clk_qzt)
    if (mem_we) mem[mem_addr] <= mem_wdata;
  always_ff @(posedge clk_qzt or negedge reset_n)
    if (!reset_n) cpu_rdata <= '0;
    else if (busy) cpu_rdata <= '0;
    else if (en) cpu_rdata <= mem[cpu_addr];
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboarded random and directed stimulus against a
// whole-array reference model of the responder.
module tb_ram_responder;
  logic clk_qzt = 0, reset_n = 0, en = 0, clk_in = 0, cpu_we = 0;
  logic ld_valid = 0, clr_req = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, ld_addr = 0, ld_data = 0;
  logic [7:0] cpu_rdata;
  logic ld_ready, busy, wr_collision;

  ram_responder dut (
    .clk_qzt(clk_qzt), .reset_n(reset_n), .en(en), .clk_in(clk_in),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .clr_req(clr_req), .busy(busy),
    .wr_collision(wr_collision)
  );

  always #5 clk_qzt = ~clk_qzt;

  int cyc = 0;
  always @(posedge clk_qzt) cyc <= cyc + 1;

  typedef struct {int cyc; int kind; logic [7:0] exp;} item_t;
  item_t q[$];
  int checks = 0, failures = 0;

  logic [7:0] mem_m [256];
  logic [7:0] rd_m = 0;
  int remaining = 0;
  bit old_m = 1;

  function automatic void push(int c, int k, logic [7:0] e);
    item_t it;
    it.cyc = c; it.kind = k; it.exp = e;
    q.push_back(it);
  endfunction

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp, int c);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, exp);
    end
  endfunction

  // monitor: compares whatever the DUT presents in the current cycle
  initial forever begin
    @(negedge clk_qzt);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      item_t it;
      it = q.pop_front();
      if (it.cyc < cyc) check("stale_item", 8'(it.cyc), 8'(cyc), cyc);
      else if (it.kind == 0) check("cpu_rdata", cpu_rdata, it.exp, cyc);
      else if (it.kind == 1) begin
        check("busy", {7'd0, busy}, it.exp, cyc);
        check("ld_ready", {7'd0, ld_ready}, {7'd0, !it.exp[0]}, cyc);
      end else check("wr_collision", {7'd0, wr_collision}, it.exp, cyc);
    end
  end

  // reference model: one clk_qzt cycle with the inputs currently driven
  task automatic step();
    bit b, t, cw;
    b = remaining > 0;
    t = clk_in && !old_m;
    cw = !b && en && t && cpu_we;
    push(cyc, 1, {7'd0, b});
    push(cyc, 2, {7'd0, !b && ld_valid && cw});
    if (b) rd_m = 0;
    else if (en) rd_m = mem_m[cpu_addr];
    push(cyc + 1, 0, rd_m);
    old_m = clk_in;
    if (b) remaining--;
    else begin
      if (ld_valid) mem_m[ld_addr] = ld_data;
      else if (cw) mem_m[cpu_addr] = cpu_wdata;
      if (clr_req) begin
        remaining = 256;
        foreach (mem_m[i]) mem_m[i] = 0;
      end
    end
    @(posedge clk_qzt); #1;
  endtask

  task automatic drive(bit e, bit ci, logic [7:0] a, logic [7:0] wd, bit we,
                       bit lv, logic [7:0] la, logic [7:0] ldd, bit cr);
    en = e; clk_in = ci; cpu_addr = a; cpu_wdata = wd; cpu_we = we;
    ld_valid = lv; ld_addr = la; ld_data = ldd; clr_req = cr;
    step();
  endtask

  task automatic do_reset(int n);
    reset_n = 0;
    q.delete();
    for (int i = 0; i < n; i++) begin
      push(cyc, 1, 8'd1);
      push(cyc, 0, 8'd0);
      push(cyc, 2, 8'd0);
      @(posedge clk_qzt); #1;
    end
    reset_n = 1;
    remaining = 256;
    old_m = 1;
    rd_m = 0;
    foreach (mem_m[i]) mem_m[i] = 0;
  endtask

  task automatic idle(int n, logic [7:0] a);
    for (int i = 0; i < n; i++) drive(1, clk_in, a, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = 0;
    @(posedge clk_qzt); #1;
    do_reset(3);
    clk_in = 1;
    idle(258, 8'h33);
    // loader burst then read back
    drive(1, 0, 8'h10, 0, 0, 1, 8'h10, 8'h06, 0);
    drive(1, 0, 8'h10, 0, 0, 1, 8'h11, 8'h2A, 0);
    drive(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 8'h11, 0, 0, 0, 0, 0, 0);
    idle(2, 8'h11);
    // clk_in held high for 10 cycles, write data changed meanwhile
    drive(1, 0, 8'h40, 8'h5A, 1, 0, 0, 0, 0);
    drive(1, 1, 8'h40, 8'h5A, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(1, 1, 8'h40, 8'h77, 1, 0, 0, 0, 0);
    drive(1, 0, 8'h40, 8'h77, 0, 0, 0, 0, 0);
    idle(2, 8'h40);
    // loader and CPU tick write collide on the same address
    drive(1, 1, 8'h40, 8'h22, 1, 1, 8'h40, 8'h11, 0);
    drive(1, 0, 8'h40, 0, 0, 0, 0, 0, 0);
    idle(2, 8'h40);
    // en=0 tick write is ignored and rdata holds
    drive(1, 0, 8'h20, 0, 0, 1, 8'h20, 8'h3C, 0);
    drive(1, 0, 8'h20, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 8'h20, 8'hFF, 1, 0, 0, 0, 0);
    drive(0, 0, 8'h55, 8'hFF, 1, 0, 0, 0, 0);
    idle(2, 8'h20);
    // clear request, interrupted by reset at clr_cnt=100
    drive(1, 0, 8'h10, 0, 0, 0, 0, 0, 1);
    idle(100, 8'h10);
    do_reset(3);
    clk_in = 0;
    idle(258, 8'h10);
    drive(1, 0, 8'h11, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 8'h40, 0, 0, 0, 0, 0, 0);
    idle(1, 8'h40);
    // clear request from READY runs a full clear
    drive(1, 0, 8'h40, 0, 0, 1, 8'h41, 8'h99, 1);
    idle(260, 8'h41);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) != 0, ($urandom_range(0, 2) == 0) ? !clk_in : clk_in,
            8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 3, 8'($urandom_range(0, 15)), 8'($urandom),
            $urandom_range(0, 599) == 0);
    end
    clr_req = 0; ld_valid = 0; cpu_we = 0;
    @(posedge clk_qzt); #1;
    @(posedge clk_qzt); #1;
    check("queue_drained", 8'(q.size()), 8'd0, cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
